// File: rtl/pc_sequencer_pkg.sv
// Shared state encodings, fault codes and helpers for the program-counter sequencer.
package pc_sequencer_pkg;

    localparam int unsigned STATE_W     = 3;
    localparam int unsigned CAUSE_W     = 2;
    localparam int unsigned INSTR_BYTES = 4;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [CAUSE_W-1:0] cause_t;

    localparam logic [2:0] ST_BOOT  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_HALT  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    // Instruction addresses must be word aligned.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_select.sv
// Next-PC priority mux (halt > jump > branch > pc+4) with misaligned-target detection.
module pc_sequencer_next_pc_select
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            halt_req,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            take_branch,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] target_c,
    output logic            misaligned_c
);

    logic [XLEN-1:0] pc_inc;

    assign pc_inc = pc + XLEN'(INSTR_BYTES);

    // Halt advances past the halting instruction; only redirects can misalign.
    always_comb begin
        target_c     = pc_inc;
        misaligned_c = 1'b0;
        if (halt_req) begin
            target_c = pc_inc;
        end else if (jump) begin
            target_c     = jump_target;
            misaligned_c = !is_aligned(jump_target[1:0]);
        end else if (take_branch) begin
            target_c     = branch_target;
            misaligned_c = !is_aligned(branch_target[1:0]);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: sequences BOOT/FETCH/EXEC, handles halt/resume, faults and retire count.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC      = '0,
    parameter int unsigned     FETCH_TIMEOUT = 16,
    parameter int unsigned     CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    output logic             instr_valid,
    input  logic             take_branch,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             jump,
    input  logic [XLEN-1:0]  jump_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [XLEN-1:0]  pc,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned TO_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_d;
    logic [CNT_W-1:0] retired_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    cause_t           cause_d;
    logic [XLEN-1:0]  target_c;
    logic             misaligned_c;

    pc_sequencer_next_pc_select #(
        .XLEN (XLEN)
    ) u_next_pc_select (
        .pc            (pc),
        .halt_req      (halt_req),
        .jump          (jump),
        .jump_target   (jump_target),
        .take_branch   (take_branch),
        .branch_target (branch_target),
        .target_c      (target_c),
        .misaligned_c  (misaligned_c)
    );

    assign imem_addr = pc;

    // Next-state and datapath update; control inputs only matter in EXEC.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc;
        retired_d = retired;
        to_cnt_d  = '0;
        cause_d   = fault_cause;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d = ST_EXEC;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if ((FETCH_TIMEOUT != 0) && (to_cnt_q == TO_W'(FETCH_TIMEOUT - 1))) begin
                        state_d = ST_FAULT;
                        cause_d = FC_TIMEOUT;
                    end
                end
            end
            ST_EXEC: begin
                retired_d = retired + CNT_W'(1);
                if (halt_req) begin
                    pc_d    = target_c;
                    state_d = ST_HALT;
                end else if (misaligned_c) begin
                    state_d = ST_FAULT;
                    cause_d = FC_MISALIGN;
                end else begin
                    pc_d    = target_c;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, datapath and status flags; flags are decoded from the next state so they are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc          <= RESET_PC;
            retired     <= '0;
            to_cnt_q    <= '0;
            fault_cause <= FC_NONE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            retired     <= retired_d;
            to_cnt_q    <= to_cnt_d;
            fault_cause <= cause_d;
            imem_req    <= (state_d == ST_FETCH);
            instr_valid <= (state_d == ST_EXEC);
            halted      <= (state_d == ST_HALT);
            fault       <= (state_d == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned CNT_W         = 32;
    localparam int unsigned FETCH_TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_ready;
    logic             instr_valid;
    logic             take_branch;
    logic [XLEN-1:0]  branch_target;
    logic             jump;
    logic [XLEN-1:0]  jump_target;
    logic             halt_req;
    logic             resume;
    logic [XLEN-1:0]  pc;
    logic             halted;
    logic             fault;
    logic [1:0]       fault_cause;
    logic [CNT_W-1:0] retired;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .XLEN          (XLEN),
        .RESET_PC      (32'h0000_0000),
        .FETCH_TIMEOUT (FETCH_TIMEOUT),
        .CNT_W         (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .instr_valid   (instr_valid),
        .take_branch   (take_branch),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc            (pc),
        .halted        (halted),
        .fault         (fault),
        .fault_cause   (fault_cause),
        .retired       (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_ctl;
        take_branch   = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        halt_req      = 1'b0;
    endtask

    // Advance one cycle into FETCH and check the request.
    task automatic expect_fetch(input logic [XLEN-1:0] addr);
        nclk(1);
        clr_ctl();
        check("fetch_req", 64'(imem_req), 64'd1);
        check("fetch_addr", 64'(imem_addr), 64'(addr));
        check("fetch_iv", 64'(instr_valid), 64'd0);
    endtask

    task automatic expect_exec;
        nclk(1);
        check("exec_iv", 64'(instr_valid), 64'd1);
        check("exec_req", 64'(imem_req), 64'd0);
    endtask

    task automatic reset_pulse;
        rst = 1'b1;
        #1;
        check("rst_pc", 64'(pc), 64'h0);
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_cause", 64'(fault_cause), 64'd0);
        check("rst_req", 64'(imem_req), 64'd0);
        nclk(1);
        rst        = 1'b0;
        imem_ready = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        imem_ready = 1'b0;
        resume     = 1'b0;
        clr_ctl();
        nclk(2);
        check("reset_pc", 64'(pc), 64'h0);
        check("reset_req", 64'(imem_req), 64'd0);
        check("reset_iv", 64'(instr_valid), 64'd0);
        check("reset_halted", 64'(halted), 64'd0);
        check("reset_fault", 64'(fault), 64'd0);
        check("reset_cause", 64'(fault_cause), 64'd0);
        check("reset_retired", 64'(retired), 64'd0);
        rst        = 1'b0;
        imem_ready = 1'b1;

        // Sequential fetch 0x0, 0x4, 0x8 then taken branch to 0x40
        expect_fetch(32'h0);
        expect_exec();
        expect_fetch(32'h4);
        expect_exec();
        expect_fetch(32'h8);
        check("retired_2", 64'(retired), 64'd2);
        expect_exec();
        take_branch   = 1'b1;
        branch_target = 32'h40;
        expect_fetch(32'h40);
        check("retired_3", 64'(retired), 64'd3);

        // Jump beats branch
        expect_exec();
        take_branch   = 1'b1;
        branch_target = 32'h80;
        jump          = 1'b1;
        jump_target   = 32'h100;
        expect_fetch(32'h100);
        expect_exec();
        take_branch   = 1'b1;
        branch_target = 32'h20;
        expect_fetch(32'h20);

        // Halt at 0x20 beats a simultaneous jump
        expect_exec();
        halt_req    = 1'b1;
        jump        = 1'b1;
        jump_target = 32'h200;
        nclk(1);
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_pc", 64'(pc), 64'h24);
        check("halt_req_low", 64'(imem_req), 64'd0);
        check("halt_retired", 64'(retired), 64'd6);
        nclk(2);
        check("halt_hold", 64'(halted), 64'd1);
        check("halt_hold_pc", 64'(pc), 64'h24);
        check("halt_hold_iv", 64'(instr_valid), 64'd0);
        clr_ctl();
        imem_ready = 1'b0;
        resume     = 1'b1;
        nclk(1);
        resume = 1'b0;
        check("resume_halted", 64'(halted), 64'd0);
        check("resume_req", 64'(imem_req), 64'd1);
        check("resume_addr", 64'(imem_addr), 64'h24);

        // Ready arriving on the 16th FETCH cycle avoids the timeout
        for (int i = 2; i <= 16; i++) begin
            nclk(1);
            check("wait_req", 64'(imem_req), 64'd1);
            check("wait_nofault", 64'(fault), 64'd0);
        end
        imem_ready = 1'b1;
        nclk(1);
        check("late_ready_iv", 64'(instr_valid), 64'd1);
        check("late_ready_nofault", 64'(fault), 64'd0);
        imem_ready = 1'b0;

        // No ready for 16 FETCH cycles -> timeout fault
        nclk(1);
        check("to_addr", 64'(imem_addr), 64'h28);
        for (int i = 2; i <= 16; i++) begin
            nclk(1);
            check("to_wait_nofault", 64'(fault), 64'd0);
        end
        nclk(1);
        check("to_fault", 64'(fault), 64'd1);
        check("to_cause", 64'(fault_cause), 64'd2);
        check("to_req", 64'(imem_req), 64'd0);
        check("to_pc", 64'(pc), 64'h28);
        check("to_retired", 64'(retired), 64'd7);
        resume = 1'b1;
        nclk(2);
        resume = 1'b0;
        check("to_sticky", 64'(fault), 64'd1);
        check("to_sticky_halted", 64'(halted), 64'd0);

        // Misaligned jump at 0x10
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            expect_fetch(32'(4 * i));
            expect_exec();
        end
        jump        = 1'b1;
        jump_target = 32'h22;
        nclk(1);
        clr_ctl();
        check("mis_fault", 64'(fault), 64'd1);
        check("mis_cause", 64'(fault_cause), 64'd1);
        check("mis_pc", 64'(pc), 64'h10);
        check("mis_req", 64'(imem_req), 64'd0);
        check("mis_iv", 64'(instr_valid), 64'd0);
        check("mis_retired", 64'(retired), 64'd5);
        resume = 1'b1;
        nclk(2);
        resume = 1'b0;
        check("mis_sticky", 64'(fault), 64'd1);
        check("mis_sticky_pc", 64'(pc), 64'h10);
        check("mis_sticky_cause", 64'(fault_cause), 64'd1);

        // pc+4 wraps to zero, then async reset mid-FETCH at 0x40
        reset_pulse();
        expect_fetch(32'h0);
        expect_exec();
        take_branch   = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        expect_fetch(32'hFFFF_FFFC);
        expect_exec();
        expect_fetch(32'h0);
        check("wrap_retired", 64'(retired), 64'd2);
        expect_exec();
        take_branch   = 1'b1;
        branch_target = 32'h40;
        imem_ready    = 1'b0;
        expect_fetch(32'h40);
        check("pre_rst_retired", 64'(retired), 64'd3);
        nclk(1);
        check("pre_rst_req", 64'(imem_req), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_pc", 64'(pc), 64'h0);
        check("async_retired", 64'(retired), 64'd0);
        check("async_fault", 64'(fault), 64'd0);
        check("async_req", 64'(imem_req), 64'd0);
        nclk(1);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences fetch/execute for the processor core.
- Issues instruction-memory requests and waits for the ready handshake.
- Qualifies one execute cycle per instruction, then selects next PC from PC+4, branch target (when take_branch from branch resolution is high) or jump target.
- Handles halt/resume, misaligned-target fault, fetch timeout and a retired-instruction counter.

Parameters:
- XLEN, 32, PC/address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- FETCH_TIMEOUT, 16, max FETCH cycles waiting for imem_ready before fault; 0 disables the timeout
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request, held high throughout FETCH
- imem_addr  out  XLEN  fetch address, always equals pc
- imem_ready  in  1  instruction valid on bus this cycle
- instr_valid  out  1  one-cycle execute qualifier to datapath/register-file write enable
- take_branch  in  1  conditional branch resolved taken
- branch_target  in  XLEN  branch destination
- jump  in  1  JAL/JALR in execute
- jump_target  in  XLEN  jump destination
- halt_req  in  1  ECALL/EBREAK/FENCE decoded in execute
- resume  in  1  leave HALT
- pc  out  XLEN  current program counter
- halted  out  1  high in HALT
- fault  out  1  high in FAULT (sticky)
- fault_cause  out  2  00 none, 01 misaligned target, 10 fetch timeout
- retired  out  CNT_W  count of executed instructions

Behaviour:
- Reset (async, any state): state=BOOT, pc=RESET_PC, retired=0, timeout counter=0, fault=0, fault_cause=00. All outputs low except pc.
- BOOT: one cycle, imem_req=0, then go to FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_ready=1 -> EXEC next cycle; timeout counter cleared.
  - Otherwise the counter increments. When FETCH_TIMEOUT!=0 and the counter reaches FETCH_TIMEOUT-1 without ready -> FAULT with cause 10.
  - Ready in the same cycle as the limit wins, so there is no fault.
- EXEC: exactly one cycle; instr_valid=1; retired increments by 1 (wraps modulo 2^CNT_W). Inputs are sampled only here and ignored in all other states.
- EXEC next-PC priority: halt_req > jump > take_branch > pc+4.
  - halt_req: pc <- pc+4, go to HALT. The instruction counts as retired.
  - jump: target = jump_target.
  - take_branch: target = branch_target.
  - Otherwise: target = pc+4, modulo 2^XLEN (wrap from all-ones-minus-3 to 0 is legal).
- Misalignment: if the selected jump/branch target has [1:0]!=00, go to FAULT with cause 01. pc is left unchanged, pointing at the faulting instruction. The instruction still retires.
- Otherwise pc <- target and go to FETCH.
- HALT: halted=1, imem_req=0. resume=1 -> FETCH next cycle. halt_req is ignored while in HALT.
- FAULT: fault=1, imem_req=0, instr_valid=0. Only reset exits; resume is ignored.
- Latency: minimum 2 cycles per instruction (FETCH with ready, then EXEC).
- Reset asserted mid-FETCH or mid-EXEC aborts immediately; no partial pc update survives.

Decomposition:
- Shared package holds:
  - state enum: BOOT, FETCH, EXEC, HALT, FAULT
  - fault_cause constants: NONE=00, MISALIGN=01, TIMEOUT=10
  - INSTR_BYTES=4
- One natural sub-module: next_pc_select. Combinational priority mux plus misalignment check; outputs target and misaligned.

Test Plan:
- Reset release, imem_ready tied 1, no control -> imem_addr sequence 0x0,0x4,0x8; instr_valid every 2nd cycle; retired=3 after three EXEC cycles.
- At pc=0x8: take_branch=1, branch_target=0x40 -> next FETCH addr 0x40. Same cycle with jump=1, jump_target=0x100 -> 0x100 (jump wins).
- At pc=0x10: jump_target=0x22 -> fault=1, fault_cause=01, pc stays 0x10, imem_req=0; resume=1 has no effect.
- FETCH_TIMEOUT=16, imem_ready held 0 -> fault_cause=10 after 16 FETCH cycles. Ready on cycle 16 -> no fault.
- At pc=0x20: halt_req=1 -> halted=1, pc=0x24. resume pulse -> FETCH at 0x24, halted=0.
- Assert rst mid-FETCH at pc=0x40 -> pc=RESET_PC, retired=0, fault=0 asynchronously before the next clock edge.
